// File: rtl/tmvp_pkg.sv
// tmvp_pkg: shared state encoding, counter width and beat-count helper for the TMVP scheduler.
package tmvp_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam int N_MAX = 16;
  localparam int CW = $clog2(2 * N_MAX);
  function automatic int beats(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/tmvp_result_collector.sv
// tmvp_result_collector: counts multiplier results, registers result-memory writes, flags spurious beats.
module tmvp_result_collector
  import tmvp_pkg::*;
#(
  parameter int N = 16,
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_active,
  input  logic          i_m_tvalid,
  input  logic [DW-1:0] i_m_tdata,
  input  logic [AW-1:0] i_res_base,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_err,
  output logic          o_all
);
  logic [CW-1:0] r_k;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_err;
  logic          w_take;
  assign w_take    = i_m_tvalid && i_active && (r_k < CW'(N));
  assign o_all     = r_k == CW'(N);
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_err     = r_err;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k       <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_take;
      if (w_take) begin
        r_wr_addr <= i_res_base + AW'(r_k);
        r_wr_data <= i_m_tdata;
      end
      if (i_m_tvalid && !w_take) r_err <= 1'b1;
      r_k <= i_start ? '0 : r_k + CW'(w_take);
    end
  end
endmodule

// File: rtl/tmvp_scheduler.sv
// tmvp_scheduler: fetches Toeplitz diagonals and vector, streams them into the multiplier,
// and writes the N dot products back to result memory.
module tmvp_scheduler
  import tmvp_pkg::*;
#(
  parameter int N = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_row_base,
  input  logic [ADDR_WIDTH-1:0] cmd_vec_base,
  input  logic [ADDR_WIDTH-1:0] cmd_res_base,
  output logic                  rd_req,
  input  logic                  rd_gnt,
  output logic [ADDR_WIDTH-1:0] row_rd_addr,
  output logic [ADDR_WIDTH-1:0] vec_rd_addr,
  input  logic [DATA_WIDTH-1:0] row_rd_data,
  input  logic [DATA_WIDTH-1:0] vec_rd_data,
  output logic [DATA_WIDTH-1:0] mvm_tdata_row,
  output logic [DATA_WIDTH-1:0] mvm_tdata_vec,
  output logic                  mvm_tvalid,
  input  logic [DATA_WIDTH-1:0] mvm_m_tdata,
  input  logic                  mvm_m_tvalid,
  output logic                  res_wr_en,
  output logic [ADDR_WIDTH-1:0] res_wr_addr,
  output logic [DATA_WIDTH-1:0] res_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_spurious
);
  localparam int BEATS = beats(N);
  state_t                r_state;
  logic [CW-1:0]         r_b;
  logic [ADDR_WIDTH-1:0] r_row_base, r_vec_base, r_res_base;
  logic                  r_tvalid, r_vec_ok, r_done;
  logic                  w_accept, w_grant, w_last, w_all;
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_grant       = rd_req && rd_gnt;
  assign w_last        = r_b == CW'(BEATS - 1);
  assign cmd_ready     = r_state == IDLE;
  assign busy          = !cmd_ready;
  assign rd_req        = r_state == FETCH;
  assign done          = r_done;
  assign row_rd_addr   = rd_req ? r_row_base + ADDR_WIDTH'(r_b) : '0;
  assign vec_rd_addr   = (rd_req && r_b < CW'(N)) ? r_vec_base + ADDR_WIDTH'(r_b) : '0;
  assign mvm_tvalid    = r_tvalid;
  assign mvm_tdata_row = r_tvalid ? row_rd_data : '0;
  // Vector beats past N carry zero so the multiplier sees only the diagonal tail.
  assign mvm_tdata_vec = (r_tvalid && r_vec_ok) ? vec_rd_data : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_b        <= '0;
      r_row_base <= '0;
      r_vec_base <= '0;
      r_res_base <= '0;
      r_tvalid   <= 1'b0;
      r_vec_ok   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tvalid <= w_grant;
      r_vec_ok <= r_b < CW'(N);
      r_done   <= 1'b0;
      if (w_accept) begin
        r_row_base <= cmd_row_base;
        r_vec_base <= cmd_vec_base;
        r_res_base <= cmd_res_base;
        r_b        <= '0;
        r_state    <= FETCH;
      end
      if (w_grant) begin
        r_b <= w_last ? '0 : r_b + CW'(1);
        if (w_last) r_state <= DRAIN;
      end
      if (r_state == DRAIN && w_all) begin
        r_state <= IDLE;
        r_done  <= 1'b1;
      end
    end
  end
  tmvp_result_collector #(.N(N), .DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_collect (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_accept),
    .i_active  (busy),
    .i_m_tvalid(mvm_m_tvalid),
    .i_m_tdata (mvm_m_tdata),
    .i_res_base(r_res_base),
    .o_wr_en   (res_wr_en),
    .o_wr_addr (res_wr_addr),
    .o_wr_data (res_wr_data),
    .o_err     (err_spurious),
    .o_all     (w_all)
  );
endmodule

// File: tb/tb_tmvp_scheduler.sv
// tb_tmvp_scheduler: scoreboard bench with memory and streaming-multiplier stubs around tmvp_scheduler.
module tb_tmvp_scheduler;
  localparam int N = 16;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NB = 2 * N - 1;
  logic          clk = 0;
  logic          reset = 0;
  logic          cmd_valid = 0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_row_base = 0, cmd_vec_base = 0, cmd_res_base = 0;
  logic          rd_req;
  logic          rd_gnt = 1;
  logic [AW-1:0] row_rd_addr, vec_rd_addr;
  logic [DW-1:0] row_rd_data = 0, vec_rd_data = 0;
  logic [DW-1:0] mvm_tdata_row, mvm_tdata_vec;
  logic          mvm_tvalid;
  logic [DW-1:0] mvm_m_tdata;
  logic          mvm_m_tvalid;
  logic          res_wr_en;
  logic [AW-1:0] res_wr_addr;
  logic [DW-1:0] res_wr_data;
  logic          busy, done, err_spurious;
  logic [DW-1:0] mem [1024];
  logic [AW+DW-1:0] q[$];
  int n_chk = 0, n_err = 0;
  int done_cnt = 0, fetch_cnt = 0, g_cnt = 0, wr_cnt = 0, tv_idx = 0;
  logic prev_mtv = 0;
  logic gnt_tog = 0;
  logic mdl_valid = 0, inj = 0;
  logic [DW-1:0] mdl_data = 0, inj_data = 0;
  assign mvm_m_tvalid = mdl_valid | inj;
  assign mvm_m_tdata  = inj ? inj_data : mdl_data;

  tmvp_scheduler #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row_base(cmd_row_base), .cmd_vec_base(cmd_vec_base), .cmd_res_base(cmd_res_base),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .row_rd_addr(row_rd_addr), .vec_rd_addr(vec_rd_addr),
    .row_rd_data(row_rd_data), .vec_rd_data(vec_rd_data),
    .mvm_tdata_row(mvm_tdata_row), .mvm_tdata_vec(mvm_tdata_vec), .mvm_tvalid(mvm_tvalid),
    .mvm_m_tdata(mvm_m_tdata), .mvm_m_tvalid(mvm_m_tvalid),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .busy(busy), .done(done), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operand memory: one-cycle read latency on a granted request.
  always @(posedge clk)
    if (rd_req && rd_gnt) begin
      row_rd_data <= mem[row_rd_addr];
      vec_rd_data <= mem[vec_rd_addr];
    end

  always @(posedge clk) begin
    #1;
    rd_gnt = gnt_tog ? !rd_gnt : 1'b1;
  end

  // Streaming multiplier stub: gathers 2N-1 beats, then emits N dot products on consecutive cycles.
  logic [DW-1:0] ra [NB];
  logic [DW-1:0] va [NB];
  logic [DW-1:0] ys [N];
  int mi = 0, mo = 0;
  always @(posedge clk) begin
    if (!reset) begin
      mi = 0;
      mo = 0;
      mdl_valid <= 1'b0;
    end else begin
      mdl_valid <= 1'b0;
      if (mo > 0) begin
        mdl_valid <= 1'b1;
        mdl_data  <= ys[N-mo];
        mo--;
      end
      if (mvm_tvalid) begin
        ra[mi] = mvm_tdata_row;
        va[mi] = mvm_tdata_vec;
        mi++;
        if (mi == NB) begin
          for (int k = 0; k < N; k++) begin
            ys[k] = 0;
            for (int j = 0; j < N; j++) ys[k] = ys[k] + ra[k+j] * va[j];
          end
          mo = N;
          mi = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) tv_idx = 0;
    if (rd_req) fetch_cnt++;
    if (rd_req && rd_gnt) g_cnt++;
    if (done) begin
      done_cnt++;
      check("done_idle", {busy, cmd_ready}, 2'b01);
    end
    if (mvm_tvalid) begin
      if (tv_idx >= N) check("vec_pad", mvm_tdata_vec, 0);
      tv_idx = (tv_idx + 1) % NB;
    end
    if (res_wr_en) begin
      wr_cnt++;
      check("wr_lat", prev_mtv, 1);
      check("wr_expected", q.size() != 0, 1);
      if (q.size() != 0) check("wr_addr_data", {res_wr_addr, res_wr_data}, q.pop_front());
    end
    prev_mtv = mvm_m_tvalid;
  end

  task automatic fill(input int base, input int len, input int mode);
    for (int i = 0; i < len; i++)
      mem[(base+i)%1024] = mode == 0 ? 8'd1 : mode == 1 ? 8'(i) : mode == 2 ? 8'd16 :
                           mode == 3 ? 8'(i == 0) : 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp(input int rb, input int vb, input int resb);
    logic [DW-1:0] s;
    logic [AW-1:0] a;
    for (int k = 0; k < N; k++) begin
      s = 0;
      for (int j = 0; j < N; j++) s = s + mem[(rb+k+j)%1024] * mem[(vb+j)%1024];
      a = AW'((resb + k) % 1024);
      q.push_back({a, s});
    end
  endtask

  task automatic start(input int rb, input int vb, input int resb);
    push_exp(rb, vb, resb);
    @(posedge clk); #1;
    cmd_valid = 1;
    cmd_row_base = AW'(rb);
    cmd_vec_base = AW'(vb);
    cmd_res_base = AW'(resb);
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    check("accept", {busy, cmd_ready, rd_req}, 3'b101);
  endtask

  task automatic wait_done(input int want);
    for (int i = 0; i < 600 && done_cnt < want; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, want);
    check("sb_empty", q.size(), 0);
  endtask

  task automatic run(input int rb, input int vb, input int resb, input logic held);
    done_cnt = 0;
    fetch_cnt = 0;
    g_cnt = 0;
    start(rb, vb, resb);
    wait_done(1);
    check("grants", g_cnt, NB);
    if (held) check("fetch_len", fetch_cnt, NB);
    else check("stall_fetch", fetch_cnt >= 2 * NB - 1, 1);
  endtask

  function automatic logic [63:0] rst_vec();
    return {rd_req, row_rd_addr, vec_rd_addr, mvm_tvalid, mvm_tdata_row, mvm_tdata_vec,
            res_wr_en, res_wr_addr, res_wr_data, busy, done, err_spurious};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_outs", rst_vec(), 0);
    @(posedge clk); #1;
    reset = 1;
    fill(0, NB, 0); fill(100, N, 0);
    run(0, 100, 200, 1);
    fill(300, NB, 1); fill(400, N, 3);
    run(300, 400, 500, 1);
    fill(600, NB, 2); fill(700, N, 0);
    run(600, 700, 1020, 1);
    gnt_tog = 1;
    run(0, 100, 40, 0);
    gnt_tog = 0;
    check("stall_no_err", err_spurious, 0);
    fill(800, NB, 4); fill(850, N, 4);
    done_cnt = 0;
    g_cnt = 0;
    start(800, 850, 900);
    for (int i = 0; i < 200 && g_cnt < 10; i++) @(negedge clk);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_outs", rst_vec(), 0);
    q.delete();
    @(posedge clk); #1;
    reset = 1;
    run(800, 850, 900, 1);
    fill(150, NB, 4); fill(250, N, 4);
    push_exp(800, 850, 960);
    push_exp(150, 250, 1000);
    done_cnt = 0;
    @(posedge clk); #1;
    cmd_valid = 1;
    cmd_row_base = 800; cmd_vec_base = 850; cmd_res_base = 960;
    @(posedge clk); #1;
    cmd_row_base = 150; cmd_vec_base = 250; cmd_res_base = 1000;
    @(negedge clk);
    check("b2b_first", {busy, cmd_ready}, 2'b10);
    for (int i = 0; i < 600 && done_cnt < 1; i++) @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    check("b2b_second", {busy, cmd_ready, rd_req}, 3'b101);
    wait_done(2);
    check("pre_spur_err", err_spurious, 0);
    wr_cnt = 0;
    @(posedge clk); #1;
    inj = 1;
    inj_data = 8'h55;
    @(posedge clk); #1;
    inj = 0;
    repeat (2) @(negedge clk);
    check("spur_err", err_spurious, 1);
    check("spur_no_write", wr_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
